// File: rtl/riscboy_ppu_bus_arbiter_pkg.sv
// riscboy_ppu_bus_arbiter_pkg: bus size encodings and width helpers shared with the fetch engines
package riscboy_ppu_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } bus_size_e;

    // Largest size code a W_DATA-bit bus can carry (16 -> half, 32 -> word)
    function automatic int bus_size_max(input int w_data);
        return $clog2(w_data) - 3;
    endfunction

    // Index width that stays at least one bit for a single requester
    function automatic int req_idx_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/riscboy_ppu_rr_pick.sv
// riscboy_ppu_rr_pick: round-robin pick of the first set request at or after ptr, wrapping
module riscboy_ppu_rr_pick
    import riscboy_ppu_bus_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int W_IDX = req_idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [W_IDX-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [W_IDX-1:0] idx
);

    // Scan from the far end back to ptr so the closest request after ptr wins
    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) idx = W_IDX'((int'(ptr) + k) % N);
        end
        onehot = |req ? N'(1) << idx : '0;
    end

endmodule

// File: rtl/riscboy_ppu_bus_arbiter.sv
// riscboy_ppu_bus_arbiter: round-robin sharing of the PPU memory read port, one transfer in flight
module riscboy_ppu_bus_arbiter
    import riscboy_ppu_bus_arbiter_pkg::*;
#(
    parameter int                N_REQ        = 4,
    parameter int                W_ADDR       = 32,
    parameter int                W_DATA       = 16,
    parameter logic [W_ADDR-1:0] ADDR_MASK    = {W_ADDR{1'b1}},
    parameter int                W_REQIDX     = req_idx_width(N_REQ),
    parameter int                BUS_SIZE_MAX = bus_size_max(W_DATA)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_vld,
    input  logic [N_REQ*W_ADDR-1:0]   req_addr,
    input  logic [N_REQ*2-1:0]        req_size,
    output logic [N_REQ-1:0]          req_rdy,
    output logic [W_DATA-1:0]         req_data,
    output logic                      mem_vld,
    output logic [W_ADDR-1:0]         mem_addr,
    output logic [1:0]                mem_size,
    input  logic                      mem_rdy,
    input  logic [W_DATA-1:0]         mem_data,
    output logic [W_REQIDX-1:0]       grant_idx
);

    localparam logic [1:0]          SIZE_CAP = 2'(BUS_SIZE_MAX);
    localparam logic [W_REQIDX-1:0] LAST     = W_REQIDX'(N_REQ - 1);

    logic                    locked, locked_d;
    logic [W_REQIDX-1:0]     grant, grant_d, ptr, ptr_d, win_idx;
    logic [W_ADDR-1:0]       addr_q, addr_d, win_addr, cur_addr;
    logic [1:0]              size_q, size_d, win_size, cur_size, eff_size;
    logic [N_REQ-1:0]        win_onehot;
    logic [BUS_SIZE_MAX-1:0] lane;
    logic                    done;

    function automatic logic [W_REQIDX-1:0] wrap_inc(input logic [W_REQIDX-1:0] i);
        return i == LAST ? '0 : i + 1'b1;
    endfunction

    riscboy_ppu_rr_pick #(
        .N     (N_REQ),
        .W_IDX (W_REQIDX)
    ) u_pick (
        .req    (req_vld),
        .ptr    (ptr),
        .onehot (win_onehot),
        .idx    (win_idx)
    );

    assign win_addr  = req_addr[win_idx*W_ADDR +: W_ADDR];
    assign win_size  = req_size[win_idx*2 +: 2];
    assign grant_idx = grant;

    // Arbitration state; the latched address and size need no reset
    always_ff @(posedge clk) begin
        if (rst) begin
            locked <= 1'b0;
            grant  <= '0;
            ptr    <= '0;
        end else begin
            locked <= locked_d;
            grant  <= grant_d;
            ptr    <= ptr_d;
        end
        addr_q <= addr_d;
        size_q <= size_d;
    end

    // Next state: lock onto a stalled winner, release and advance ptr on completion
    always_comb begin
        locked_d = locked;
        grant_d  = grant;
        ptr_d    = ptr;
        addr_d   = addr_q;
        size_d   = size_q;
        if (locked) begin
            if (mem_rdy) begin
                locked_d = 1'b0;
                ptr_d    = wrap_inc(grant);
            end
        end else if (|req_vld) begin
            grant_d = win_idx;
            if (mem_rdy) begin
                ptr_d = wrap_inc(win_idx);
            end else begin
                locked_d = 1'b1;
                addr_d   = win_addr;
                size_d   = win_size;
            end
        end
    end

    // Outputs: downstream request, completion strobe and lane-steered read data
    always_comb begin
        cur_addr = locked ? addr_q : win_addr;
        cur_size = locked ? size_q : win_size;
        mem_vld  = !rst && (locked || |req_vld);
        mem_addr = cur_addr & ADDR_MASK;
        mem_size = cur_size;
        done     = mem_vld && mem_rdy;
        eff_size = cur_size > SIZE_CAP ? SIZE_CAP : cur_size;
        lane     = cur_addr[BUS_SIZE_MAX-1:0] & ~BUS_SIZE_MAX'((32'd1 << eff_size) - 32'd1);
        req_data = mem_data >> {lane, 3'b000};
        req_rdy  = !done ? '0 : locked ? N_REQ'(1) << grant : win_onehot;
    end

endmodule
